hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Decode-stage hazard controller. It is the producer-side counterpart to the EXE forwarding selector.
- Forwarding resolves the hazards it can. This block detects and enforces the hazards forwarding cannot resolve:
  - load-use,
  - multi-cycle memory instructions (CALL/RET/INT/RTI, 32-bit PC over the 16-bit memory),
  - taken-branch flush.
- Drives the PC enable, the IF/ID write/flush and the ID/EX bubble. Keeps a saturating stall-cycle counter.

Parameters:
REG_ADDR_W, 3, register address width (8 GPRs)
MULTI_CYCLES, 2, total fetch-hold cycles for a multi-cycle memory instruction (>=2)
CNT_W, 16, stall counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
id_src_addr  in  REG_ADDR_W  source register of instruction in ID
id_dst_addr  in  REG_ADDR_W  destination/second-operand register of instruction in ID
id_src_used  in  1  ID instruction reads id_src_addr
id_dst_used  in  1  ID instruction reads id_dst_addr
id_multi_mem  in  1  ID instruction is multi-cycle memory op
ex_dst_addr  in  REG_ADDR_W  destination of instruction in EX
ex_mem_read  in  1  EX instruction is a memory load (LDD/POP)
ex_wb_en  in  1  EX instruction writes the register file
ex_branch_taken  in  1  branch/jump resolved taken in EX
pc_write  out  1  PC register load enable
ifid_write  out  1  IF/ID register load enable
ifid_flush  out  1  IF/ID cleared to NOP on next edge
idex_bubble  out  1  ID/EX loaded with NOP control on next edge
stall  out  1  any stall/flush active this cycle
stall_count  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Reset: all state clears asynchronously.
  - FSM=RUN, hold counter=0, stall_count=0.
  - While rst=1, every 1-bit output is 0.
- FSM states: RUN, MULTI. Outputs are Mealy (same cycle as the inputs).
- Load-use hit (luh) is defined as: ex_mem_read & ex_wb_en & ((id_src_used & id_src_addr==ex_dst_addr) | (id_dst_used & id_dst_addr==ex_dst_addr)).
- Priority per cycle: branch > luh > multi > normal.
- Branch (any state):
  - Outputs: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1, stall=1.
  - Next state RUN, hold counter cleared. An in-progress MULTI is aborted.
- RUN with luh:
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1, stall=1.
  - Stays in RUN. The load advances, so the stall lasts exactly one cycle and the following cycle forwards from MEM.
- RUN with id_multi_mem and no luh (entry cycle):
  - The instruction issues (idex_bubble=0).
  - pc_write=0, ifid_flush=1, stall=1.
  - Hold counter loads MULTI_CYCLES-1; next state MULTI.
- MULTI:
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1, stall=1.
  - Counter decrements each cycle. When the counter is 1, next state is RUN.
  - id_multi_mem and luh are ignored in MULTI (IF/ID holds NOP).
  - Total fetch-hold = MULTI_CYCLES cycles, including the entry cycle.
- RUN, no event: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, stall=0.
- stall_count increments on every rising edge where stall=1 and saturates at all-ones (no wrap).
- Address compare is exact on REG_ADDR_W bits. Unused operands never match. A load with ex_wb_en=0 never stalls.

Decomposition:
- Shared pipeline package holds:
  - state encoding (RUN=1'b0, MULTI=1'b1),
  - REG_ADDR_W,
  - the NOP control word used for bubbles.
- One sub-module, hazard_addr_match: combinational luh computation. Reused by the forwarding path tests.

Test Plan:
- Load-use: ex_mem_read=1, ex_wb_en=1, ex_dst_addr=3, id_src_used=1, id_src_addr=3 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1. Next cycle (EX no longer a load) shows the normal outputs. stall_count=1.
- No false stall: same as above but id_src_used=0, or ex_wb_en=0, or id_src_addr=4 -> stall=0 throughout.
- Multi-cycle, MULTI_CYCLES=2: id_multi_mem=1 in RUN.
  - Entry cycle: idex_bubble=0, ifid_flush=1, pc_write=0.
  - One MULTI cycle: bubble=1, pc_write=0.
  - Then RUN.
  - stall_count +2.
- Branch abort: ex_branch_taken=1 in the first MULTI cycle (MULTI_CYCLES=4) -> ifid_flush=1, idex_bubble=1, pc_write=1. Next cycle is RUN with normal outputs.
- Priority: branch and luh in the same cycle -> branch outputs only (pc_write=1).
- Reset mid-MULTI: assert rst asynchronously between edges -> outputs 0 immediately, stall_count=0. After release, the FSM is in RUN with normal outputs.
- Saturation: preload via 65535 stall cycles with CNT_W=16 -> stall_count holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared decode-stage pipeline definitions: FSM encoding, register address width, control words.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_stall_unit_pkg;

  // 8 general-purpose registers.
  localparam int REG_ADDR_W = 3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_MULTI = 1'b1
  } hz_state_t;

  // ID/EX control word loaded when a bubble is inserted: no writeback,
  // no memory access, no branch. All-zero by construction of the decoder.
  localparam logic [15:0] NOP_CTRL_WORD = 16'h0000;

  // Per-cycle hazard control outputs, bundled so each case below is one word.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic stall;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_OFF    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam hz_ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  // Taken branch: wrong-path fetch is squashed but the PC moves to the target.
  localparam hz_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  // Load-use: freeze PC and IF/ID for one cycle, bubble into EX.
  localparam hz_ctrl_t CTRL_LUH    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  // Multi-cycle entry: instruction issues, fetch holds, IF/ID becomes NOP.
  localparam hz_ctrl_t CTRL_ENTRY  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam hz_ctrl_t CTRL_MULTI  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

endpackage

// File: rtl/hazard_addr_match.sv
// Load-use hit detection: EX-stage load destination vs ID-stage source operands.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: ex_mem_read/ex_wb_en/ex_dst_addr describe the EX instruction;
//        id_*_addr/id_*_used describe the ID operands; luh is the hit flag.
module hazard_addr_match #(
  parameter int REG_ADDR_W = 3
) (
  input  logic                  ex_mem_read,
  input  logic                  ex_wb_en,
  input  logic [REG_ADDR_W-1:0] ex_dst_addr,
  input  logic [REG_ADDR_W-1:0] id_src_addr,
  input  logic [REG_ADDR_W-1:0] id_dst_addr,
  input  logic                  id_src_used,
  input  logic                  id_dst_used,
  output logic                  luh
);

  logic src_hit;
  logic dst_hit;

  // Operands the ID instruction does not read can never create a hazard.
  assign src_hit = id_src_used && (id_src_addr == ex_dst_addr);
  assign dst_hit = id_dst_used && (id_dst_addr == ex_dst_addr);

  // A load that does not write back (e.g. discarded result) never stalls.
  assign luh = ex_mem_read && ex_wb_en && (src_hit || dst_hit);

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard controller: load-use stall, multi-cycle memory hold, taken-branch flush.
// Latency: control outputs are combinational (Mealy) on the current-cycle inputs; counter updates on the edge.
// Backpressure: stalls fetch by dropping pc_write/ifid_write; no upstream handshake.
// Ports: clk/rst; id_* (ID operands and multi-mem flag); ex_* (EX load/writeback/branch);
//        pc_write, ifid_write, ifid_flush, idex_bubble, stall; stall_count (saturating).
module hazard_stall_unit #(
  parameter int REG_ADDR_W   = 3,
  parameter int MULTI_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src_addr,
  input  logic [REG_ADDR_W-1:0] id_dst_addr,
  input  logic                  id_src_used,
  input  logic                  id_dst_used,
  input  logic                  id_multi_mem,
  input  logic [REG_ADDR_W-1:0] ex_dst_addr,
  input  logic                  ex_mem_read,
  input  logic                  ex_wb_en,
  input  logic                  ex_branch_taken,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count
);

  import hazard_stall_unit_pkg::*;

  // Hold counter only needs to reach MULTI_CYCLES-1.
  localparam int HOLD_W = (MULTI_CYCLES > 2) ? $clog2(MULTI_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(MULTI_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  hz_state_t         state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  hz_ctrl_t          ctrl;
  logic              luh;

  hazard_addr_match #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_addr_match (
    .ex_mem_read (ex_mem_read),
    .ex_wb_en    (ex_wb_en),
    .ex_dst_addr (ex_dst_addr),
    .id_src_addr (id_src_addr),
    .id_dst_addr (id_dst_addr),
    .id_src_used (id_src_used),
    .id_dst_used (id_dst_used),
    .luh         (luh)
  );

  always_comb begin
    ctrl    = CTRL_NORMAL;
    state_d = state_q;
    hold_d  = hold_q;
    if (rst) begin
      // Outputs are forced quiet while reset is held, independent of the edge.
      ctrl = CTRL_OFF;
    end else if (ex_branch_taken) begin
      // Branch wins over everything and aborts an in-flight multi-cycle hold.
      ctrl    = CTRL_BRANCH;
      state_d = ST_RUN;
      hold_d  = '0;
    end else if (state_q == ST_MULTI) begin
      // IF/ID holds a NOP here, so ID-side hazards are meaningless.
      ctrl   = CTRL_MULTI;
      hold_d = hold_q - HOLD_ONE;
      if (hold_q == HOLD_ONE) begin
        state_d = ST_RUN;
      end
    end else if (luh) begin
      // The load moves on to MEM, so one cycle is enough; forwarding covers the rest.
      ctrl = CTRL_LUH;
    end else if (id_multi_mem) begin
      ctrl    = CTRL_ENTRY;
      state_d = ST_MULTI;
      hold_d  = HOLD_INIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      hold_q      <= '0;
      stall_count <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (ctrl.stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign stall       = ctrl.stall;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: two instances (MULTI_CYCLES=2 and 4) share one stimulus.
// Latency: outputs checked at the falling edge of the cycle they belong to.
// Backpressure: n/a.
module tb_hazard_stall_unit;

  // Output vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, stall}
  localparam logic [4:0] NORM = 5'b11000;
  localparam logic [4:0] BR   = 5'b11111;
  localparam logic [4:0] LUH  = 5'b00011;
  localparam logic [4:0] ENT  = 5'b00101;
  localparam logic [4:0] MUL  = 5'b00011;
  localparam logic [4:0] MF   = 5'b11111;  // all outputs defined
  localparam logic [4:0] MENT = 5'b10111;  // ifid_write not defined on entry
  localparam logic [4:0] MMUL = 5'b11011;  // ifid_flush not defined in MULTI

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] id_src_addr, id_dst_addr, ex_dst_addr;
  logic       id_src_used, id_dst_used, id_multi_mem;
  logic       ex_mem_read, ex_wb_en, ex_branch_taken;

  logic        pw2, iw2, fl2, bb2, st2;
  logic        pw4, iw4, fl4, bb4, st4;
  logic [15:0] cnt2, cnt4;

  hazard_stall_unit #(.REG_ADDR_W(3), .MULTI_CYCLES(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst),
    .id_src_addr(id_src_addr), .id_dst_addr(id_dst_addr),
    .id_src_used(id_src_used), .id_dst_used(id_dst_used),
    .id_multi_mem(id_multi_mem), .ex_dst_addr(ex_dst_addr),
    .ex_mem_read(ex_mem_read), .ex_wb_en(ex_wb_en),
    .ex_branch_taken(ex_branch_taken),
    .pc_write(pw2), .ifid_write(iw2), .ifid_flush(fl2),
    .idex_bubble(bb2), .stall(st2), .stall_count(cnt2)
  );

  hazard_stall_unit #(.REG_ADDR_W(3), .MULTI_CYCLES(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst),
    .id_src_addr(id_src_addr), .id_dst_addr(id_dst_addr),
    .id_src_used(id_src_used), .id_dst_used(id_dst_used),
    .id_multi_mem(id_multi_mem), .ex_dst_addr(ex_dst_addr),
    .ex_mem_read(ex_mem_read), .ex_wb_en(ex_wb_en),
    .ex_branch_taken(ex_branch_taken),
    .pc_write(pw4), .ifid_write(iw4), .ifid_flush(fl4),
    .idex_bubble(bb4), .stall(st4), .stall_count(cnt4)
  );

  logic [4:0] o2, o4;
  assign o2 = {pw2, iw2, fl2, bb2, st2};
  assign o4 = {pw4, iw4, fl4, bb4, st4};

  typedef struct {
    string       name;
    logic [4:0]  mask2;
    logic [4:0]  mask4;
    logic [4:0]  e2;
    logic [4:0]  e4;
    logic [15:0] ec2;
    logic [15:0] ec4;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [15:0] m2 = 16'd0;
  logic [15:0] m4 = 16'd0;

  task automatic cmp5(input string n, input logic [4:0] act, input logic [4:0] exp,
                      input logic [4:0] mask);
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s outputs got %b expected %b (mask %b)", n, act, exp, mask);
    end
  endtask

  task automatic cmp16(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s stall_count got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic idle();
    id_src_addr = 3'd0; id_dst_addr = 3'd0; ex_dst_addr = 3'd0;
    id_src_used = 1'b0; id_dst_used = 1'b0; id_multi_mem = 1'b0;
    ex_mem_read = 1'b0; ex_wb_en = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic set_luh(input logic [2:0] dst, input logic [2:0] src);
    ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_dst_addr = dst;
    id_src_used = 1'b1; id_src_addr = src;
  endtask

  // Issue one cycle of already-driven inputs; expected counts are the
  // values the counter holds during this cycle, before its closing edge.
  task automatic cyc(input string n, input logic [4:0] mk2, input logic [4:0] e2,
                     input logic [4:0] mk4, input logic [4:0] e4);
    exp_t e;
    e.name = n; e.mask2 = mk2; e.mask4 = mk4; e.e2 = e2; e.e4 = e4;
    e.ec2 = m2; e.ec4 = m4;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (e2[0] && m2 != 16'hFFFF) m2 = m2 + 16'd1;
    if (e4[0] && m4 != 16'hFFFF) m4 = m4 + 16'd1;
  endtask

  task automatic cyc_both(input string n, input logic [4:0] mk, input logic [4:0] e);
    cyc(n, mk, e, mk, e);
  endtask

  // Monitor: every cycle carries a result; compare the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp5({e.name, "_mc2"}, o2, e.e2, e.mask2);
        cmp5({e.name, "_mc4"}, o4, e.e4, e.mask4);
        cmp16({e.name, "_mc2"}, cnt2, e.ec2);
        cmp16({e.name, "_mc4"}, cnt4, e.ec4);
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    #3;
    cmp5("reset_mc2", o2, 5'b00000, MF);
    cmp5("reset_mc4", o4, 5'b00000, MF);
    cmp16("reset_mc2", cnt2, 16'd0);
    cmp16("reset_mc4", cnt4, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    idle(); cyc_both("idle", MF, NORM);

    // Load-use on source operand, then the load has moved on.
    idle(); set_luh(3'd3, 3'd3); cyc_both("luh_src", MF, LUH);
    idle(); cyc_both("luh_after", MF, NORM);

    // No false stalls.
    idle(); set_luh(3'd3, 3'd3); id_src_used = 1'b0; cyc_both("nf_unused", MF, NORM);
    idle(); set_luh(3'd3, 3'd3); ex_wb_en = 1'b0;    cyc_both("nf_nowb", MF, NORM);
    idle(); set_luh(3'd3, 3'd4);                     cyc_both("nf_addr", MF, NORM);
    idle(); ex_mem_read = 1'b0; ex_wb_en = 1'b1; ex_dst_addr = 3'd3;
    id_src_used = 1'b1; id_src_addr = 3'd3;          cyc_both("nf_noload", MF, NORM);

    // Load-use on the second operand.
    idle(); ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_dst_addr = 3'd7;
    id_dst_used = 1'b1; id_dst_addr = 3'd7;          cyc_both("luh_dst", MF, LUH);
    idle(); cyc_both("luh_dst_after", MF, NORM);

    // Multi-cycle: mc2 holds 2 cycles, mc4 holds 4. A second multi op
    // reaching ID while mc4 is still holding is ignored there.
    idle(); id_multi_mem = 1'b1; cyc_both("multi_entry", MENT, ENT);
    idle();                      cyc_both("multi_1", MMUL, MUL);
    idle(); id_multi_mem = 1'b1; cyc("multi_2", MENT, ENT, MMUL, MUL);
    idle(); set_luh(3'd2, 3'd2); cyc_both("multi_3_luh_ignored", MMUL, MUL);
    idle();                      cyc_both("multi_done", MF, NORM);

    // Branch abort in the first MULTI cycle.
    idle(); id_multi_mem = 1'b1;    cyc_both("abort_entry", MENT, ENT);
    idle(); ex_branch_taken = 1'b1; cyc_both("abort_branch", MF, BR);
    idle();                         cyc_both("abort_after", MF, NORM);

    // Priority: branch beats load-use and multi entry.
    idle(); set_luh(3'd5, 3'd5); ex_branch_taken = 1'b1; cyc_both("prio_br_luh", MF, BR);
    idle(); id_multi_mem = 1'b1; ex_branch_taken = 1'b1; cyc_both("prio_br_multi", MF, BR);
    idle(); cyc_both("prio_after", MF, NORM);

    // Asynchronous reset between edges while mid-MULTI.
    idle(); id_multi_mem = 1'b1; cyc_both("rst_entry", MENT, ENT);
    idle();
    #1 rst = 1'b1;
    #1;
    cmp5("rst_async_mc2", o2, 5'b00000, MF);
    cmp5("rst_async_mc4", o4, 5'b00000, MF);
    cmp16("rst_async_mc2", cnt2, 16'd0);
    cmp16("rst_async_mc4", cnt4, 16'd0);
    m2 = 16'd0; m4 = 16'd0;
    @(posedge clk); #3;
    cmp5("rst_held_mc4", o4, 5'b00000, MF);
    rst = 1'b0;
    @(posedge clk); #1;
    idle(); cyc_both("rst_release", MF, NORM);
    idle(); cyc_both("rst_release_2", MF, NORM);

    // Saturation: continuous branch flushes stall every cycle.
    idle(); ex_branch_taken = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      cyc_both("sat", MF, BR);
    end
    idle(); cyc_both("sat_idle", MF, NORM);
    @(negedge clk);
    cmp16("sat_hold_mc2", cnt2, 16'hFFFF);
    cmp16("sat_hold_mc4", cnt4, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
